pr_arb_sched: RTL
=================

Name: pr_arb_sched

Overview:
- Clocked four-master priority arbiter/scheduler for one shared slave resource.
- Replaces purely combinational priority selection with registered, one-hot grants and grant hold (bus ownership).
- Bounds ownership with a programmable hold limit; optional aging prevents starvation of low-priority masters.
- Sits between masters M0..M3 and the shared resource select.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one master may hold a grant (legal range 1..255).
- AGE_MAX, 7, saturation value of each per-master age counter (3-bit counter).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = master Mi.
- pri  input  12  static priorities; pri[3i+2:3i] = Pi; 0 lowest, 7 highest.
- gnt  output  4  registered one-hot grant; all zero when no owner.
- gnt_id  output  2  index of current owner; 0 when gnt==0.
- busy  output  1  high while any gnt bit is set.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, gnt_id=0, busy=0.
  - State=IDLE; hold_cnt=0; all age counters=0.
- State machine has two states: IDLE and OWN.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose winner w = argmax(eff_i) over requesting i; tie goes to lowest index.
  - eff_i = Pi + age_i, 4-bit unsigned, no overflow (max 14).
  - Next edge: gnt=1<<w, gnt_id=w, busy=1, hold_cnt=1, state=OWN.
  - Latency: req sampled at edge N, gnt visible after edge N+1.
- OWN (owner o):
  - If req[o]==0: gnt=0, busy=0, state=IDLE at next edge (release latency 1 cycle).
  - Else if hold_cnt==MAX_HOLD: forced release. gnt=0, state=IDLE at next edge, regardless of req[o].
  - Else: hold grant; hold_cnt++.
- Dead cycle:
  - There is always at least one IDLE cycle with gnt=0 between two owners.
  - A forced-released master with req still high competes normally in that IDLE cycle.
- Aging (when compiled in):
  - At each IDLE arbitration, every requesting loser increments age_i, saturating at AGE_MAX.
  - The winner's age resets to 0.
  - Any master with req_i==0 has age_i cleared that cycle.
  - Ages do not change in OWN.
- pri is sampled only in IDLE; changes during OWN have no effect on the current owner.
- Requests from non-owners during OWN are ignored (no queueing, no aging).
- Asserting rst_n low mid-ownership drops gnt immediately (asynchronously).
- gnt is never multi-hot; gnt_id and busy always stay consistent with gnt.

Optional Feature:
- Macro: PR_ARB_AGING_EN.
- Defined: aging as described; eff_i = Pi + age_i.
- Undefined:
  - No age counters are synthesized; eff_i = Pi.
  - Pure static priority with lowest-index tie-break.
  - Starvation of low-priority masters is possible and accepted.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, gnt_id=0, busy=0. Release reset -> gnt=4'b1000 one cycle after the first sampled edge (pri P3=5, P0=2, P1=4, P2=3).
- Tie-break: req=4'b0110, P1=P2=4 -> gnt=4'b0010, gnt_id=1.
- Hold limit: MAX_HOLD=8, req[0] held high alone -> gnt=4'b0001 for exactly 8 cycles, then 1 cycle gnt=0, then gnt=4'b0001 again.
- Early release: M2 granted, req[2] drops in its 3rd grant cycle -> gnt=0 on the next edge, busy=0.
- Aging (PR_ARB_AGING_EN defined):
  - Setup: P0=1, P3=5, req=4'b1001 continuous, MAX_HOLD=1.
  - M3 wins the first 4 arbitrations.
  - After 4 losses age_0=4 (eff_0=5 ties eff_3=5), so M0 wins by lowest index.
  - Without the macro, M3 wins every arbitration.
- Async reset mid-OWN: rst_n pulled low during cycle 2 of M1 ownership -> gnt=0 without waiting for clk; after release the next arbitration starts from IDLE with all ages 0.

Source files
------------

// File: rtl/pr_arb_sched.sv
// Four-master registered priority arbiter with grant hold, a hold limit and optional aging.
// Define PR_ARB_AGING_EN to build the per-master age counters that prevent starvation.
module pr_arb_sched #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned AGE_MAX  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] pri,
  output logic [3:0]  gnt,
  output logic [1:0]  gnt_id,
  output logic        busy
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || AGE_MAX > 7) begin : g_bad_param
    $error("pr_arb_sched: MAX_HOLD must be 1..255 and AGE_MAX must fit in 3 bits");
  end

  state_t     state;
  logic [7:0] hold_cnt;
  logic [3:0] eff [4];
  logic [3:0] best_eff;
  logic       found;
  logic [1:0] win_id;

`ifdef PR_ARB_AGING_EN
  localparam logic [2:0] AGE_SAT = 3'(AGE_MAX);
  logic [2:0] age [4];
`endif

  // Effective priority is 4 bits wide so priority plus age never wraps.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
`ifdef PR_ARB_AGING_EN
      eff[i] = {1'b0, pri[3*i +: 3]} + {1'b0, age[i]};
`else
      eff[i] = {1'b0, pri[3*i +: 3]};
`endif
    end
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    win_id   = '0;
    best_eff = '0;
    found    = 1'b0;
    // Strict greater-than keeps the lowest index on ties.
    for (int i = 0; i < 4; i++) begin
      if (req[i] && (!found || eff[i] > best_eff)) begin
        win_id   = 2'(i);
        best_eff = eff[i];
        found    = 1'b1;
      end
    end
  end

  // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
`ifdef PR_ARB_AGING_EN
      for (int i = 0; i < 4; i++) age[i] <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            gnt      <= 4'b0001 << win_id;
            gnt_id   <= win_id;
            busy     <= 1'b1;
            hold_cnt <= 8'd1;
            state    <= OWN;
          end
`ifdef PR_ARB_AGING_EN
          // Idle masters and the winner restart at zero; requesting losers age.
          for (int i = 0; i < 4; i++) begin
            if (!req[i] || 2'(i) == win_id)
              age[i] <= '0;
            else if (age[i] != AGE_SAT)
              age[i] <= age[i] + 3'd1;
          end
`endif
        end
        OWN: begin
          if (!req[gnt_id] || hold_cnt == HOLD_LIM) begin
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
